// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package debounce_pkg;

  localparam int unsigned NBITS_SWI = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Counter width for a stability count of n samples, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable flop and
// optional rise/fall pulse flops (built only when SWI_DEBOUNCER_EDGE_EN is defined).
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_2,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            commit;

  // Next-state: count consecutive samples that disagree with the stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      commit   = 1'b1;
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

`ifdef SWI_DEBOUNCER_EDGE_EN
  logic rise_q, fall_q;

  // Edge pulses land on the same edge the stable level changes.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= commit & s2_q;
      fall_q <= commit & ~s2_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign dout    = stable_q;
  assign pending = (cnt_q != '0);

endmodule

// File: rtl/swi_debouncer.sv
// Debounces the board slide switches bit by bit.
// Define SWI_DEBOUNCER_EDGE_EN to build the SWI_RISE/SWI_FALL pulse registers;
// otherwise both are tied low.
module swi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NBITS           = NBITS_SWI,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] SWI_STABLE,
  output logic [NBITS-1:0] SWI_RISE,
  output logic [NBITS-1:0] SWI_FALL,
  output logic             busy
);

  logic [NBITS-1:0] pending;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_2  (clk_2),
      .reset  (reset),
      .din    (SWI[i]),
      .dout   (SWI_STABLE[i]),
      .rise   (SWI_RISE[i]),
      .fall   (SWI_FALL[i]),
      .pending(pending[i])
    );
  end

  assign busy = |pending;

endmodule

// File: tb/tb_swi_debouncer.sv
// Self-checking bench for swi_debouncer: directed scenarios plus random switch
// activity, all compared against a sample-window reference model.
module tb_swi_debouncer;

  localparam int unsigned DC = 4;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] SWI = 8'h00;
  logic [7:0] SWI_STABLE, SWI_RISE, SWI_FALL;
  logic       busy;

  int total  = 0;
  int passes = 0;

  // Reference model state: 2-stage delay line of raw samples, and the window of
  // the last DC delayed samples seen since reset.
  logic [7:0] pipe[$];
  logic [7:0] win[$];
  logic [7:0] m_stable = 8'h00;
  logic [7:0] m_rise   = 8'h00;
  logic [7:0] m_fall   = 8'h00;
  logic       m_busy   = 1'b0;

  swi_debouncer #(
    .NBITS(8),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .SWI       (SWI),
    .SWI_STABLE(SWI_STABLE),
    .SWI_RISE  (SWI_RISE),
    .SWI_FALL  (SWI_FALL),
    .busy      (busy)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] edge_exp(input logic [7:0] v);
`ifdef SWI_DEBOUNCER_EDGE_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  // Apply one clock edge with the given inputs, advance the model, compare.
  task automatic step(input logic rst, input logic [7:0] sw);
    logic [7:0] used;
    logic       all_diff;
    reset = rst;
    SWI   = sw;
    @(posedge clk_2);
    if (rst) begin
      pipe.delete();
      pipe.push_back(8'h00);
      pipe.push_back(8'h00);
      win.delete();
      m_stable = 8'h00;
      m_rise   = 8'h00;
      m_fall   = 8'h00;
    end else begin
      used = pipe.pop_front();
      pipe.push_back(sw);
      win.push_back(used);
      if (win.size() > DC) void'(win.pop_front());
      m_rise = 8'h00;
      m_fall = 8'h00;
      for (int b = 0; b < 8; b++) begin
        all_diff = (win.size() == DC);
        for (int j = 0; j < win.size(); j++) begin
          if (win[j][b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stable[b] = used[b];
          if (used[b]) m_rise[b] = 1'b1;
          else         m_fall[b] = 1'b1;
        end
      end
    end
    m_busy = 1'b0;
    if (win.size() > 0) m_busy = |(win[$] ^ m_stable);
    #1;
    chk("stable", SWI_STABLE, m_stable);
    chk("rise", SWI_RISE, edge_exp(m_rise));
    chk("fall", SWI_FALL, edge_exp(m_fall));
    chk("busy", {7'b0, busy}, {7'b0, m_busy});
  endtask

  initial begin
    logic [7:0] sw;

    // Reset with switches low.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00);
      chk("rst_stable", SWI_STABLE, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
    end
    step(1'b0, 8'h00);

    // Clean step to 8'h80: commits on the fifth edge after first sampling.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h80);
      chk("step80_stable", SWI_STABLE, (i >= DC + 1) ? 8'h80 : 8'h00);
      chk("step80_rise", SWI_RISE, edge_exp((i == DC + 1) ? 8'h80 : 8'h00));
    end

    // Bounce on bit 6 shorter than the debounce window.
    for (int i = 0; i < 3; i++) step(1'b0, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h80);
      chk("bounce_stable", SWI_STABLE, 8'h80);
      chk("bounce_rise", SWI_RISE, 8'h00);
    end
    chk("bounce_busy", {7'b0, busy}, 8'h00);

    // Two bits swap on the same edge.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h40);
      chk("swap_stable", SWI_STABLE, (i >= DC + 1) ? 8'h40 : 8'h80);
      chk("swap_rise", SWI_RISE, edge_exp((i == DC + 1) ? 8'h40 : 8'h00));
      chk("swap_fall", SWI_FALL, edge_exp((i == DC + 1) ? 8'h80 : 8'h00));
    end

    // Reset in the middle of a pending count discards it.
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h01);
    chk("mid_busy_before", {7'b0, busy}, 8'h01);
    step(1'b1, 8'h01);
    chk("mid_rst_stable", SWI_STABLE, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 8'h01);
      chk("mid_rel_stable", SWI_STABLE, (i >= DC + 2) ? 8'h01 : 8'h00);
      chk("mid_rel_rise", SWI_RISE, edge_exp((i == DC + 2) ? 8'h01 : 8'h00));
    end

    // Random switch activity with bounces and occasional resets.
    sw = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) sw = sw ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
      step(($urandom_range(0, 99) == 0), sw);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
